// File: rtl/multicycle_alu_pkg.sv
// multicycle_alu_pkg: function codes and flag bundle shared by the ALU and its combinational core.
package multicycle_alu_pkg;
  localparam int FUNC_W = 4;
  localparam logic [FUNC_W-1:0] FUNC_ADD = 4'd0;
  localparam logic [FUNC_W-1:0] FUNC_SUB = 4'd1;
  localparam logic [FUNC_W-1:0] FUNC_NOT = 4'd2;
  localparam logic [FUNC_W-1:0] FUNC_AND = 4'd3;
  localparam logic [FUNC_W-1:0] FUNC_ORR = 4'd4;
  localparam logic [FUNC_W-1:0] FUNC_TCP = 4'd5;
  localparam logic [FUNC_W-1:0] FUNC_SHL = 4'd6;
  localparam logic [FUNC_W-1:0] FUNC_SHR = 4'd7;
  localparam logic [FUNC_W-1:0] FUNC_ASR = 4'd8;
  localparam logic [FUNC_W-1:0] FUNC_MUL = 4'd9;
  localparam logic [FUNC_W-1:0] FUNC_SLT = 4'd10;
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;
endpackage

// File: rtl/multicycle_alu_comb_core.sv
// alu_comb_core: single-cycle ALU ops and flags; MUL yields zero here and is produced by the parent FSM.
module alu_comb_core
  import multicycle_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [FUNC_W-1:0] i_func,
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  output logic [WIDTH-1:0]  o_c,
  output flags_t            o_flags,
  output logic              o_err
);
  localparam int M = WIDTH - 1;
  logic [WIDTH:0] w_add;
  logic [WIDTH:0] w_sub;
  logic signed [WIDTH-1:0] w_asr;
  // Native shift semantics already give 0 / sign fill once B reaches WIDTH.
  always_comb begin
    w_add = {1'b0, i_a} + {1'b0, i_b};
    w_sub = {1'b0, i_a} - {1'b0, i_b};
    w_asr = $signed(i_a) >>> i_b;
    o_err = i_func > FUNC_SLT;
    o_c = i_func == FUNC_ADD ? w_add[M:0] :
          i_func == FUNC_SUB ? w_sub[M:0] :
          i_func == FUNC_NOT ? ~i_a :
          i_func == FUNC_AND ? i_a & i_b :
          i_func == FUNC_ORR ? i_a | i_b :
          i_func == FUNC_TCP ? -i_a :
          i_func == FUNC_SHL ? i_a << i_b :
          i_func == FUNC_SHR ? i_a >> i_b :
          i_func == FUNC_ASR ? w_asr :
          i_func == FUNC_SLT ? {{M{1'b0}}, $signed(i_a) < $signed(i_b)} : '0;
    o_flags.z = ~o_err & ~|o_c;
    o_flags.n = o_c[M];
    o_flags.c = i_func == FUNC_ADD ? w_add[WIDTH] :
                i_func == FUNC_SUB ? w_sub[WIDTH] : 1'b0;
    o_flags.v = i_func == FUNC_ADD ? (i_a[M] == i_b[M]) & (w_add[M] != i_a[M]) :
                i_func == FUNC_SUB ? (i_a[M] != i_b[M]) & (w_sub[M] != i_a[M]) : 1'b0;
  end
endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: valid/ready ALU with single-cycle ops and a WIDTH-cycle shift-add multiply.
module multicycle_alu
  import multicycle_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FUNC_W-1:0] funcCode,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  C,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              flag_v,
  output logic              out_err
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  state_t r_state;
  state_t w_next;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] w_c;
  flags_t r_flags;
  flags_t w_flags;
  logic r_err;
  logic w_err;
  logic w_accept;
  logic w_mul_done;
  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .i_func (funcCode),
    .i_a    (A),
    .i_b    (B),
    .o_c    (w_c),
    .o_flags(w_flags),
    .o_err  (w_err)
  );
  assign w_accept = in_valid & in_ready;
  assign w_mul_done = (r_state == S_MUL) & (r_cnt == LAST);
  assign w_acc_next = r_mplier[0] ? r_acc + r_mcand : r_acc;
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // Accept from IDLE or draining HOLD takes priority: that is what allows back-to-back ops.
  always_comb begin
    w_next = w_accept ? (funcCode == FUNC_MUL ? S_MUL : S_HOLD) :
             r_state == S_MUL ? (w_mul_done ? S_HOLD : S_MUL) :
             r_state == S_HOLD ? (out_ready ? S_IDLE : S_HOLD) : S_IDLE;
  end
  always_comb begin
    in_ready = reset_n & ((r_state == S_IDLE) | ((r_state == S_HOLD) & out_ready));
    out_valid = r_state == S_HOLD;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mcand <= '0;
      r_mplier <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept && funcCode == FUNC_MUL) begin
      r_mcand <= {{WIDTH{1'b0}}, A};
      r_mplier <= B;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == S_MUL) begin
      r_acc <= w_acc_next;
      r_mcand <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_c <= '0;
      r_flags <= '0;
      r_err <= 1'b0;
    end else if (w_accept && funcCode != FUNC_MUL) begin
      r_c <= w_c;
      r_flags <= w_flags;
      r_err <= w_err;
    end else if (w_mul_done) begin
      r_c <= w_acc_next[WIDTH-1:0];
      r_flags <= '{z: ~|w_acc_next[WIDTH-1:0], n: w_acc_next[WIDTH-1],
                   c: |w_acc_next[2*WIDTH-1:WIDTH], v: 1'b0};
      r_err <= 1'b0;
    end
  end
  assign C = r_c;
  assign flag_z = r_flags.z;
  assign flag_n = r_flags.n;
  assign flag_c = r_flags.c;
  assign flag_v = r_flags.v;
  assign out_err = r_err;
endmodule
